rx_dfe: RTL
===========

# rx_dfe

Receive-side decision-feedback equalizer with slicer and lock monitor. It consumes the real-valued output of the lossy channel model and cancels post-cursor ISI by subtracting weighted past decisions. It slices the result to a bit and optionally adapts the feedback taps with sign-sign LMS. It sits directly downstream of the channel in the analog_blocks behavioural receive path and feeds the digital deserializer/checker.

## Interface
- NTAPS, 2, number of feedback taps (1..4)
- MU, 0.002, real adaptation step
- SIG_AMP, 1.0, real target symbol amplitude for error computation
- TAP_INIT, 0.0, real reset value of every tap
- TAP_MAX, 0.5, real tap clamp magnitude
- ERR_THR, 0.1, real good-symbol error threshold
- LOCK_CNT, 64, consecutive good symbols to declare lock
- LOSS_CNT, 8, consecutive bad symbols to drop lock

Ports:
- clk  in  1  symbol clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- rx_in  in  real  channel output sample
- adapt_en  in  1  enables adaptation / lock acquisition
- data_out  out  1  sliced decision
- eq_out  out  real  equalized sample before slicing
- tap0_out  out  real  current value of first tap
- locked  out  1  lock indicator

## Operation
- Decision history d[k], k=0..NTAPS-1, held as ±1; d[0] is the most recent decision.
- Each cycle: eq = rx_in − Σ tap[k]·d[k]; dec = (eq >= 0.0); e = eq − (dec ? +SIG_AMP : −SIG_AMP).
- Registered: data_out<=dec, eq_out<=eq, history shifts with d[0]<=(dec?+1:−1).
- Adaptation when state≠IDLE: tap[k] <= clamp(tap[k] + MU·sgn(e)·d[k], ±TAP_MAX). sgn(0.0)=0, so the tap holds.
- Good symbol: |e| < ERR_THR.
- FSM:
  - IDLE: taps frozen, locked=0. Moves to TRAIN when adapt_en=1.
  - TRAIN: good-counter increments on a good symbol and clears on a bad one. Moves to LOCKED when the counter reaches LOCK_CNT.
  - LOCKED: locked=1. Bad-counter increments on a bad symbol and clears on a good one. At LOSS_CNT it returns to TRAIN with both counters cleared.
  - adapt_en=0 in any state forces IDLE next cycle and clears the counters. This has priority over every other transition, including a simultaneous lock or loss event.
- Counters saturate and never wrap.

## Timing
- Reset values:
  - data_out=0, eq_out=0.0, locked=0, tap0_out=TAP_INIT
  - all d[k]=−1, all taps=TAP_INIT, state=IDLE, counters=0
- Reset asserted mid-operation restores all of the above on the next posedge, regardless of state.
- Latency: rx_in sampled at edge n appears in data_out/eq_out after edge n. Tap updates using that sample are visible after edge n and apply to the sample at edge n+1.
- locked rises on the edge where the good-counter reaches LOCK_CNT. It falls on the edge where the bad-counter reaches LOSS_CNT, or on the edge that enters IDLE.
- tap0_out is registered and equals tap[0].

## Configuration
- RX_DFE_ADAPT_EN defined:
  - LMS update logic present.
  - Taps adapt as above.
- RX_DFE_ADAPT_EN undefined:
  - No update logic; taps are constant TAP_INIT.
  - The FSM and lock monitor still run; locked then acts as an eye-quality monitor.
  - All ports remain present.

## Structure
- Package rx_dfe_pkg holds:
  - state enum (IDLE, TRAIN, LOCKED)
  - real sgn() and clamp() functions
  - default constants for LOCK_CNT, LOSS_CNT, TAP_MAX
- Sub-module rx_dfe_lock_fsm holds the state machine and both counters. Inputs: clk, rst, adapt_en, good. Outputs: state, locked.

## Test plan
- Reset: rst=1 for 3 cycles with rx_in=0.7 -> data_out=0, eq_out=0.0, locked=0, tap0_out=TAP_INIT; state IDLE after deassert.
- Fixed taps: adapt_en=0, TAP_INIT=0.0, rx_in alternating +1.0/−1.0 -> data_out=1,0,1,0 one edge later; eq_out equals rx_in; taps unchanged.
- Convergence (macro on): rx_in=a[n]+0.3·a[n−1] with a from PRBS7 (±1.0), adapt_en=1 -> tap0_out within 0.3±0.01 by 2000 cycles; locked=1; data_out matches a[n].
- Clamp: rx_in=+2.0 constant, adapt_en=1, TAP_MAX=0.5 -> tap0_out rises by 0.002/cycle and holds at exactly 0.5.
- Loss/priority: after lock, rx_in=0.0 for 8 cycles -> locked falls on the 8th edge and state returns to TRAIN. Separately, drop adapt_en on the cycle the good-counter reaches LOCK_CNT -> locked stays 0, state IDLE, taps frozen.
- Mid-run reset: assert rst while LOCKED with tap0_out≈0.3 -> next edge restores all reset values.

Source files
------------

// File: rtl/rx_dfe_pkg.sv
// rx_dfe_pkg: state encoding, lock-monitor defaults and real-valued helpers shared by
// the decision-feedback equalizer and its lock FSM.
package rx_dfe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t TRAIN  = 2'd1;
  localparam state_t LOCKED = 2'd2;

  localparam int  DEF_LOCK_CNT = 64;
  localparam int  DEF_LOSS_CNT = 8;
  localparam real DEF_TAP_MAX  = 0.5;

  // Zero maps to zero so a perfect decision leaves the taps untouched.
  function automatic real sgn(input real x);
    if (x > 0.0) return 1.0;
    else if (x < 0.0) return -1.0;
    else return 0.0;
  endfunction

  function automatic real clamp(input real x, input real lim);
    if (x > lim) return lim;
    else if (x < -lim) return -lim;
    else return x;
  endfunction

endpackage

// File: rtl/rx_dfe_lock_fsm.sv
// rx_dfe_lock_fsm: IDLE/TRAIN/LOCKED controller with saturating good/bad symbol counters.
// Dropping adapt_en always wins and returns the machine to IDLE with cleared counters.
module rx_dfe_lock_fsm
  import rx_dfe_pkg::*;
#(
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adapt_en,
  input  logic       good,
  output logic [1:0] state,
  output logic       locked
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  state_t        state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  logic          locked_q, locked_d;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (!adapt_en) begin
      state_d    = IDLE;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = TRAIN;
        TRAIN: begin
          if (!good) good_cnt_d = '0;
          else if (good_cnt_q != GW'(LOCK_CNT)) good_cnt_d = good_cnt_q + GW'(1);
          if (good_cnt_d == GW'(LOCK_CNT)) state_d = LOCKED;
        end
        LOCKED: begin
          if (good) bad_cnt_d = '0;
          else if (bad_cnt_q != BW'(LOSS_CNT)) bad_cnt_d = bad_cnt_q + BW'(1);
          if (bad_cnt_d == BW'(LOSS_CNT)) begin
            state_d    = TRAIN;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Registered from the next state so locked changes on the same edge as the state.
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign state  = state_q;
  assign locked = locked_q;

endmodule

// File: rtl/rx_dfe.sv
// rx_dfe: decision-feedback equalizer with slicer, optional sign-sign LMS tap adaptation
// (enabled by defining RX_DFE_ADAPT_EN) and a lock monitor.
module rx_dfe
  import rx_dfe_pkg::*;
#(
  parameter int  NTAPS    = 2,
  parameter real MU       = 0.002,
  parameter real SIG_AMP  = 1.0,
  parameter real TAP_INIT = 0.0,
  parameter real TAP_MAX  = DEF_TAP_MAX,
  parameter real ERR_THR  = 0.1,
  parameter int  LOCK_CNT = DEF_LOCK_CNT,
  parameter int  LOSS_CNT = DEF_LOSS_CNT
) (
  input  logic clk,
  input  logic rst,
  input  real  rx_in,
  input  logic adapt_en,
  output logic data_out,
  output real  eq_out,
  output real  tap0_out,
  output logic locked
);

  // History bit 1 stands for a +1 decision, 0 for -1; bit 0 is the most recent.
  logic [NTAPS-1:0] hist_q, hist_d;
  real              tap_q [NTAPS];
  real              tap_d [NTAPS];
  real              eq_q, eq_d, err;
  logic             dec_q, dec;
  logic             good;
  logic [1:0]       state;

  always_comb begin
    eq_d = rx_in;
    for (int k = 0; k < NTAPS; k++) eq_d = eq_d - tap_q[k] * (hist_q[k] ? 1.0 : -1.0);
    dec  = (eq_d >= 0.0);
    err  = eq_d - (dec ? SIG_AMP : -SIG_AMP);
    good = (err < ERR_THR) && (err > -ERR_THR);

    hist_d[0] = dec;
    for (int k = 1; k < NTAPS; k++) hist_d[k] = hist_q[k-1];

`ifdef RX_DFE_ADAPT_EN
    for (int k = 0; k < NTAPS; k++)
      tap_d[k] = (state != IDLE)
               ? clamp(tap_q[k] + MU * sgn(err) * (hist_q[k] ? 1.0 : -1.0), TAP_MAX)
               : tap_q[k];
`else
    for (int k = 0; k < NTAPS; k++) tap_d[k] = TAP_INIT;
`endif
  end

`ifndef RX_DFE_ADAPT_EN
  // Without adaptation the state and step size have no consumer in this module.
  logic unused_state;
  real  unused_mu;
  assign unused_state = ^state;
  assign unused_mu    = MU;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q  <= 1'b0;
      eq_q   <= 0.0;
      hist_q <= '0;
      for (int k = 0; k < NTAPS; k++) tap_q[k] <= TAP_INIT;
    end else begin
      dec_q  <= dec;
      eq_q   <= eq_d;
      hist_q <= hist_d;
      for (int k = 0; k < NTAPS; k++) tap_q[k] <= tap_d[k];
    end
  end

  rx_dfe_lock_fsm #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .adapt_en (adapt_en),
    .good     (good),
    .state    (state),
    .locked   (locked)
  );

  assign data_out = dec_q;
  assign eq_out   = eq_q;
  assign tap0_out = tap_q[0];

endmodule
